// File: rtl/vga_if.sv
// vga_if: groups the VGA generator's enable, color input, counters, strobes and pin outputs.
interface vga_if;
  logic        en;
  logic [7:0]  color_in;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        pix_tick;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        hsync;
  logic        vsync;
  logic [2:0]  red;
  logic [2:0]  green;
  logic [1:0]  blue;
  modport master (
    input  en, color_in,
    output hc, vc, pix_tick, line_start, frame_start, frame_cnt, hsync, vsync, red, green, blue
  );
  modport slave (
    output en, color_in,
    input  hc, vc, pix_tick, line_start, frame_start, frame_cnt, hsync, vsync, red, green, blue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel divider, h/v counters, strobes and one-pixel-delayed sync/color output stage.
module vga_timing_gen #(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  vga_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] div_q, div_d;
  logic [9:0]    hc_q, hc_d, vc_q, vc_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]    rgb_q, rgb_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          tick, h_wrap, v_wrap, active, hs_raw, vs_raw;
  // rst_n gates the tick so CLK_DIV=1 cannot strobe while held in reset
  always_comb begin
    tick        = rst_n && bus.en && (div_q == DIV_LAST);
    h_wrap      = hc_q == 10'(H_TOTAL - 1);
    v_wrap      = vc_q == 10'(V_TOTAL - 1);
    active      = (hc_q < 10'(H_ACTIVE)) && (vc_q < 10'(V_ACTIVE));
    hs_raw      = (hc_q >= 10'(H_ACTIVE + H_FP)) && (hc_q < 10'(H_ACTIVE + H_FP + H_SYNC));
    vs_raw      = (vc_q >= 10'(V_ACTIVE + V_FP)) && (vc_q < 10'(V_ACTIVE + V_FP + V_SYNC));
    div_d       = bus.en ? ((div_q == DIV_LAST) ? '0 : div_q + DW'(1)) : div_q;
    hc_d        = tick ? (h_wrap ? 10'd0 : hc_q + 10'd1) : hc_q;
    vc_d        = (tick && h_wrap) ? (v_wrap ? 10'd0 : vc_q + 10'd1) : vc_q;
    frame_cnt_d = frame_cnt_q + 16'(tick && h_wrap && v_wrap);
    hsync_d     = tick ? (hs_raw ? SYNC_ACTIVE : !SYNC_ACTIVE) : hsync_q;
    vsync_d     = tick ? (vs_raw ? SYNC_ACTIVE : !SYNC_ACTIVE) : vsync_q;
    rgb_d       = tick ? (active ? bus.color_in : 8'h00) : rgb_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      hc_q        <= '0;
      vc_q        <= '0;
      frame_cnt_q <= '0;
      hsync_q     <= !SYNC_ACTIVE;
      vsync_q     <= !SYNC_ACTIVE;
      rgb_q       <= '0;
    end else begin
      div_q       <= div_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      frame_cnt_q <= frame_cnt_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      rgb_q       <= rgb_d;
    end
  end
  assign bus.pix_tick    = tick;
  assign bus.line_start  = tick && h_wrap;
  assign bus.frame_start = tick && h_wrap && v_wrap;
  assign bus.hc          = hc_q;
  assign bus.vc          = vc_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.red         = rgb_q[7:5];
  assign bus.green       = rgb_q[4:2];
  assign bus.blue        = rgb_q[1:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default-size generator plus small-frame and CLK_DIV=1 variants.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   cmp = 0;
  int   bad = 0;
  vga_if bm();
  vga_if bs();
  vga_if b1();
  vga_timing_gen dut (.clk(clk), .rst_n(rst_n), .bus(bm));
  vga_timing_gen #(.CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));
  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_main(input int h, input int v, input int lim);
    int n = 0;
    while (!(bm.hc == 10'(h) && bm.vc == 10'(v)) && n < lim) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if (n >= lim) begin
      bad++;
      $display("FAIL wait_main: stuck at hc=%0d vc=%0d, required hc=%0d vc=%0d", bm.hc, bm.vc, h, v);
    end
  endtask
  task automatic wait_small(input int h, input int v, input int lim);
    int n = 0;
    while (!(bs.hc == 10'(h) && bs.vc == 10'(v)) && n < lim) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if (n >= lim) begin
      bad++;
      $display("FAIL wait_small: stuck at hc=%0d vc=%0d, required hc=%0d vc=%0d", bs.hc, bs.vc, h, v);
    end
  endtask
  task automatic wait_ls(output int t);
    int n = 0;
    while (!bm.line_start && n < 2000) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    cmp++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL wait_ls: no line_start within 2000 clks");
    end
  endtask
  task automatic wait_fs(output int t);
    int n = 0;
    while (!bs.frame_start && n < 500) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    cmp++;
    if (n >= 500) begin
      bad++;
      $display("FAIL wait_fs: no frame_start within 500 clks");
    end
  endtask
  task automatic test_reset();
    bm.color_in = 8'hFF;
    do_reset();
    wait_main(300, 3, 6000);
    cmp++;
    if (bm.red !== 3'd7) begin bad++; $display("FAIL pre_reset_red: got %0d want 7", bm.red); end
    #1 rst_n = 1'b0;
    #1;
    cmp++;
    if ({bm.hc, bm.vc} !== 20'd0) begin bad++; $display("FAIL rst_hcvc: got hc=%0d vc=%0d want 0/0", bm.hc, bm.vc); end
    cmp++;
    if (bm.frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_frame_cnt: got %0d want 0", bm.frame_cnt); end
    cmp++;
    if ({bm.hsync, bm.vsync} !== 2'b11) begin bad++; $display("FAIL rst_sync: got %b%b want 11", bm.hsync, bm.vsync); end
    cmp++;
    if ({bm.red, bm.green, bm.blue} !== 8'h00) begin bad++; $display("FAIL rst_rgb: got %h want 00", {bm.red, bm.green, bm.blue}); end
    cmp++;
    if ({bm.pix_tick, bm.line_start, bm.frame_start, b1.pix_tick} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_strobes: got %b want 0000", {bm.pix_tick, bm.line_start, bm.frame_start, b1.pix_tick});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    cmp++;
    if (bm.pix_tick !== 1'b0) begin bad++; $display("FAIL tick_clk0: got %b want 0", bm.pix_tick); end
    @(negedge clk);
    cmp++;
    if (bm.pix_tick !== 1'b1 || bm.hc !== 10'd0) begin bad++; $display("FAIL first_tick: got tick=%b hc=%0d want 1/0", bm.pix_tick, bm.hc); end
    @(negedge clk);
    cmp++;
    if (bm.pix_tick !== 1'b0 || bm.hc !== 10'd1) begin bad++; $display("FAIL after_first_tick: got tick=%b hc=%0d want 0/1", bm.pix_tick, bm.hc); end
  endtask
  task automatic test_hsync();
    int lo = 0, first = -1, last = -1, t1, t2;
    do_reset();
    wait_main(656, 0, 2000);
    cmp++;
    if (bm.hsync !== 1'b1) begin bad++; $display("FAIL hsync_656: got %b want 1", bm.hsync); end
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (bm.hsync == 1'b0) begin
        lo++;
        if (first < 0) first = int'(bm.hc);
        last = int'(bm.hc);
      end
    end
    cmp++;
    if (lo != 192) begin bad++; $display("FAIL hsync_width: got %0d clks want 192", lo); end
    cmp++;
    if (first != 657 || last != 752) begin bad++; $display("FAIL hsync_window: got hc %0d..%0d want 657..752", first, last); end
    wait_ls(t1);
    cmp++;
    if (bm.hc !== 10'd799) begin bad++; $display("FAIL ls_hc: got %0d want 799", bm.hc); end
    @(negedge clk);
    wait_ls(t2);
    cmp++;
    if (t2 - t1 != 1600) begin bad++; $display("FAIL line_period: got %0d want 1600", t2 - t1); end
  endtask
  task automatic test_color();
    do_reset();
    wait_main(638, 10, 20000);
    bm.color_in = 8'h1F;
    repeat (2) @(negedge clk);
    cmp++;
    if (bm.hc !== 10'd639 || {bm.red, bm.green, bm.blue} !== 8'h1F) begin
      bad++;
      $display("FAIL color_638: got hc=%0d rgb=%h want 639/1f", bm.hc, {bm.red, bm.green, bm.blue});
    end
    bm.color_in = 8'hE0;
    repeat (2) @(negedge clk);
    cmp++;
    if (bm.red !== 3'd7 || {bm.green, bm.blue} !== 5'd0) begin
      bad++;
      $display("FAIL color_639: got r=%0d g=%0d b=%0d want 7/0/0", bm.red, bm.green, bm.blue);
    end
    bm.color_in = 8'h03;
    repeat (2) @(negedge clk);
    cmp++;
    if ({bm.red, bm.green, bm.blue} !== 8'h00) begin bad++; $display("FAIL blank_640: got %h want 00", {bm.red, bm.green, bm.blue}); end
    bs.color_in = 8'hFF;
    wait_small(2, 5, 500);
    repeat (2) @(negedge clk);
    cmp++;
    if ({bs.red, bs.green, bs.blue} !== 8'hFF) begin bad++; $display("FAIL color_lastrow: got %h want ff", {bs.red, bs.green, bs.blue}); end
    wait_small(2, 6, 500);
    repeat (2) @(negedge clk);
    cmp++;
    if ({bs.red, bs.green, bs.blue} !== 8'h00) begin bad++; $display("FAIL blank_vactive: got %h want 00", {bs.red, bs.green, bs.blue}); end
  endtask
  task automatic test_stall();
    int t0, t1, odd = 0;
    do_reset();
    wait_main(100, 0, 2000);
    t0 = cyc;
    wait_ls(t1);
    cmp++;
    if (t1 - t0 != 1399) begin bad++; $display("FAIL ls_unstalled: got %0d want 1399", t1 - t0); end
    do_reset();
    wait_main(100, 0, 2000);
    t0 = cyc;
    bm.en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if (bm.hc !== 10'd100 || bm.pix_tick || bm.line_start || bm.frame_start || bm.hsync !== 1'b1) odd++;
    end
    cmp++;
    if (odd != 0) begin bad++; $display("FAIL stall_frozen: got %0d moving clks want 0", odd); end
    bm.en = 1'b1;
    wait_ls(t1);
    cmp++;
    if (t1 - t0 != 1436) begin bad++; $display("FAIL ls_stalled: got %0d want 1436", t1 - t0); end
  endtask
  task automatic test_vsync();
    int lo = 0, fh = -1, fv = -1, t1, t2;
    do_reset();
    for (int i = 0; i < 384; i++) begin
      @(negedge clk);
      if (bs.vsync == 1'b0) begin
        lo++;
        if (fh < 0) begin fh = int'(bs.hc); fv = int'(bs.vc); end
      end
    end
    cmp++;
    if (lo != 64) begin bad++; $display("FAIL vsync_width: got %0d clks want 64", lo); end
    cmp++;
    if (fh != 1 || fv != 8) begin bad++; $display("FAIL vsync_start: got hc=%0d vc=%0d want 1/8", fh, fv); end
    wait_fs(t1);
    cmp++;
    if (bs.hc !== 10'd15 || bs.vc !== 10'd11 || bs.line_start !== 1'b1 || bs.frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL fs_state: got hc=%0d vc=%0d ls=%b fc=%0d want 15/11/1/1", bs.hc, bs.vc, bs.line_start, bs.frame_cnt);
    end
    @(negedge clk);
    cmp++;
    if (bs.hc !== 10'd0 || bs.vc !== 10'd0 || bs.frame_cnt !== 16'd2) begin
      bad++;
      $display("FAIL wrap: got hc=%0d vc=%0d fc=%0d want 0/0/2", bs.hc, bs.vc, bs.frame_cnt);
    end
    wait_fs(t2);
    cmp++;
    if (t2 - t1 != 384) begin bad++; $display("FAIL frame_period: got %0d want 384", t2 - t1); end
  endtask
  task automatic test_overflow();
    int t;
    @(negedge clk);
    force dut_s.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_s.frame_cnt_q;
    wait_fs(t);
    cmp++;
    if (bs.frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL fc_preload: got %h want ffff", bs.frame_cnt); end
    @(negedge clk);
    cmp++;
    if (bs.frame_cnt !== 16'h0000) begin bad++; $display("FAIL fc_overflow: got %h want 0000", bs.frame_cnt); end
  endtask
  task automatic test_div1();
    logic [7:0] pat = 8'b1011_0110;
    int odd = 0;
    b1.en = 1'b1;
    do_reset();
    #1;
    cmp++;
    if (b1.pix_tick !== 1'b1 || b1.hc !== 10'd0) begin bad++; $display("FAIL div1_release: got tick=%b hc=%0d want 1/0", b1.pix_tick, b1.hc); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b1.en = pat[i];
      #1;
      if (b1.pix_tick !== pat[i]) odd++;
      @(negedge clk);
    end
    cmp++;
    if (odd != 0) begin bad++; $display("FAIL div1_track: got %0d wrong clks want 0", odd); end
    cmp++;
    if (b1.hc !== 10'd6) begin bad++; $display("FAIL div1_hc: got %0d want 6", b1.hc); end
  endtask
  initial begin
    bm.en = 1'b1;
    bs.en = 1'b1;
    b1.en = 1'b1;
    bm.color_in = 8'h00;
    bs.color_in = 8'h00;
    b1.color_in = 8'h00;
    test_reset();
    test_hsync();
    test_color();
    test_stall();
    test_vsync();
    test_overflow();
    test_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
